// File: rtl/sincronizador_botoes_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_botoes_4_pkg
//  Description : Shared definitions for the button synchronizer front-end and
//                the downstream 4-to-2 access-code encoder. It provides the
//                one-hot request codes, the FSM state encodings and a helper
//                that picks the lowest-index request.
//  Revision    : 1.0 - initial release
// ============================================================================
package sincronizador_botoes_4_pkg;

  // One-hot request type carried on the encoder input bus
  typedef logic [3:0] onehot_t;

  // One-hot codes, shared with the 4-to-2 encoder
  localparam onehot_t W0 = 4'b0001;
  localparam onehot_t W1 = 4'b0010;
  localparam onehot_t W2 = 4'b0100;
  localparam onehot_t W3 = 4'b1000;

  // Output FSM state encodings
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Fixed priority: lowest index wins. The result is always zero or exactly
  // one of W0..W3, so the encoder never sees a multi-bit pattern.
  function automatic onehot_t lowest_set(input onehot_t req);
    onehot_t r;
    r = '0;
    if (req[0])      r = W0;
    else if (req[1]) r = W1;
    else if (req[2]) r = W2;
    else if (req[3]) r = W3;
    return r;
  endfunction

endpackage : sincronizador_botoes_4_pkg
`default_nettype wire

// File: rtl/sincronizador_botoes_4_if.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_botoes_4_if
//  Description : Bundle between the raw button lines / encoder consumer and
//                the button synchronizer.
//                  botoes_in   : raw, asynchronous button/sensor lines
//                  ack         : consumer has taken the current code
//                  one_hot_out : one-hot request to the encoder (0 if idle)
//                  valid       : one_hot_out carries a live request
//                  overrun     : one-cycle pulse, press on a pending channel
//                  debounced   : debounced level of each line (status LEDs)
//                modport master : the synchronizer (drives the request side)
//                modport slave  : the environment / consumer
//  Revision    : 1.0 - initial release
// ============================================================================
interface sincronizador_botoes_4_if;
  import sincronizador_botoes_4_pkg::*;

  logic [3:0] botoes_in;
  logic       ack;
  onehot_t    one_hot_out;
  logic       valid;
  logic       overrun;
  logic [3:0] debounced;

  modport master (
    input  botoes_in,
    input  ack,
    output one_hot_out,
    output valid,
    output overrun,
    output debounced
  );

  modport slave (
    output botoes_in,
    output ack,
    input  one_hot_out,
    input  valid,
    input  overrun,
    input  debounced
  );

endinterface : sincronizador_botoes_4_if
`default_nettype wire

// File: rtl/sincronizador_botoes_4_debounce_canal.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_canal
//  Description : One button channel: polarity normalisation, 2-FF
//                synchronizer, debounce counter and press-edge detector.
//  Ports       : clk    - system clock
//                reset  - asynchronous, active-high reset
//                i_raw  - raw asynchronous line
//                o_deb  - debounced level (1 = pressed)
//                o_rise - one-cycle pulse on a debounced press
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_canal
  import sincronizador_botoes_4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,  // must be >= 2
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_raw,
  output logic      o_deb,
  output logic      o_rise
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice
  localparam int          CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          w_n;
  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic          r_deb_q;
  logic [CW-1:0] r_cnt;

  // Normalise so that 1 always means "pressed"; the sync chain then resets
  // to the inactive level regardless of line polarity.
  assign w_n = i_raw ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_deb   <= 1'b0;
      r_deb_q <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= w_n;
      r_s2    <= r_s1;
      r_deb_q <= r_deb;
      if (r_s2 == r_deb) begin
        // Any sample agreeing with the current level restarts the count
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_deb  = r_deb;
  // Only presses produce an event; releases are silent
  assign o_rise = r_deb & ~r_deb_q;

endmodule : debounce_canal
`default_nettype wire

// File: rtl/sincronizador_botoes_4.sv
`default_nettype none
// ============================================================================
//  Module      : sincronizador_botoes_4
//  Description : Front-end of the 4-to-2 access-code encoder. Four raw
//                button lines are synchronised and debounced; each debounced
//                press becomes a pending request. Requests are arbitrated
//                (lowest index wins) and one one-hot code is held on the
//                encoder input until the consumer acknowledges it.
//  Ports       : clk    - system clock, rising edge
//                reset  - asynchronous, active-high reset
//                if_bus - sincronizador_botoes_4_if.master
//                         (botoes_in, ack in; one_hot_out, valid, overrun,
//                          debounced out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sincronizador_botoes_4
  import sincronizador_botoes_4_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,  // stable samples per level change
  parameter bit ACTIVE_LOW      = 1'b0     // 1 = raw lines are active-low
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  sincronizador_botoes_4_if.master  if_bus
);

  logic [3:0] w_deb;
  logic [3:0] w_rise;
  onehot_t    w_req;
  onehot_t    w_grant;
  onehot_t    w_load;
  logic [3:0] w_pending_nxt;
  logic       w_overrun_nxt;

  logic [0:0] r_state;
  logic [3:0] r_pending;
  onehot_t    r_one_hot;
  logic       r_valid;
  logic       r_overrun;

  // --------------------------------------------------------------------------
  // Per-channel synchronizer + debounce
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_canal
    debounce_canal #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .i_raw  (if_bus.botoes_in[gi]),
      .o_deb  (w_deb[gi]),
      .o_rise (w_rise[gi])
    );
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  // A press arriving this cycle can be served immediately, so the request
  // vector includes the live rise pulses as well as the stored pending bits.
  assign w_req   = r_pending | w_rise;
  assign w_grant = lowest_set(w_req);
  assign w_load  = (r_state == IDLE) ? w_grant : '0;

  // Pending update:
  //  - the loaded channel is cleared,
  //  - except when it was already pending and a new press arrives in the
  //    same cycle: the old request is loaded and the new one stays pending,
  //  - a rise that is itself loaded (channel not pending) is consumed.
  assign w_pending_nxt = (w_req & ~w_load) | (r_pending & w_rise & w_load);

  // A press on a channel that is still pending (and not being loaded now)
  // is coalesced into the existing request and flagged.
  assign w_overrun_nxt = |(r_pending & w_rise & ~w_load);

  // --------------------------------------------------------------------------
  // Output FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_one_hot <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      case (r_state)
        IDLE: begin
          if (w_req != '0) begin
            r_one_hot <= w_grant;
            r_valid   <= 1'b1;
            r_state   <= HOLD;
          end
        end
        HOLD: begin
          // Code is frozen until the consumer takes it; returning to IDLE
          // guarantees one idle cycle between back-to-back requests.
          if (if_bus.ack) begin
            r_one_hot <= '0;
            r_valid   <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          r_one_hot <= '0;
          r_valid   <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign if_bus.one_hot_out = r_one_hot;
  assign if_bus.valid       = r_valid;
  assign if_bus.overrun     = r_overrun;
  assign if_bus.debounced   = w_deb;

endmodule : sincronizador_botoes_4
`default_nettype wire
